// File: rtl/regfile_nbit_bypass_if.sv
// Register-file access bundle: one write port (byte-masked) and two read ports.
// The master drives addresses and write data; the register file (slave) returns read data.
interface regfile_nbit_bypass_if #(
  parameter int n  = 32,
  parameter int AW = 5
);
  logic            writeEnable;
  logic [AW-1:0]   writeAddr;
  logic [n/8-1:0]  byteEn;
  logic [n-1:0]    din;
  logic [AW-1:0]   rdAddrA;
  logic [AW-1:0]   rdAddrB;
  logic [n-1:0]    doutA;
  logic [n-1:0]    doutB;

  modport master (
    output writeEnable, writeAddr, byteEn, din, rdAddrA, rdAddrB,
    input  doutA, doutB
  );

  modport slave (
    input  writeEnable, writeAddr, byteEn, din, rdAddrA, rdAddrB,
    output doutA, doutB
  );
endinterface

// File: rtl/regfile_nbit_bypass.sv
// DEPTH x n register file, entry 0 hardwired to zero, byte-masked write with same-cycle
// write-to-read bypass on both read ports and an optional registered read stage.
module regfile_nbit_bypass #(
  parameter int n        = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int READ_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_nbit_bypass_if.slave  bus
);

  localparam int NBYTES = n / 8;

  if ((n % 8) != 0 || n < 8 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      AW != $clog2(DEPTH)) begin : g_cfg_error
    $error("regfile_nbit_bypass: illegal configuration n=%0d DEPTH=%0d AW=%0d", n, DEPTH, AW);
  end

  logic [n-1:0] mem [DEPTH];
  logic [n-1:0] write_merged;
  logic         write_live;
  logic [n-1:0] read_a;
  logic [n-1:0] read_b;

  assign write_live = bus.writeEnable && (bus.writeAddr != '0);

  // The merged word is what the target entry will hold after this edge; reads bypass to it.
  always_comb begin
    write_merged = mem[bus.writeAddr];
    for (int k = 0; k < NBYTES; k++) begin
      if (bus.byteEn[k]) begin
        write_merged[8*k +: 8] = bus.din[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_live) begin
      mem[bus.writeAddr] <= write_merged;
    end
  end

  always_comb begin
    read_a = '0;
    if (bus.rdAddrA != '0) begin
      read_a = (write_live && bus.writeAddr == bus.rdAddrA) ? write_merged : mem[bus.rdAddrA];
    end
  end

  always_comb begin
    read_b = '0;
    if (bus.rdAddrB != '0) begin
      read_b = (write_live && bus.writeAddr == bus.rdAddrB) ? write_merged : mem[bus.rdAddrB];
    end
  end

  if (READ_REG != 0) begin : g_read_reg
    logic [n-1:0] dout_a_q;
    logic [n-1:0] dout_b_q;

    // Registered copy of the bypassed read, so cycle t+1 shows the value after cycle t's write.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_a_q <= '0;
        dout_b_q <= '0;
      end else begin
        dout_a_q <= read_a;
        dout_b_q <= read_b;
      end
    end

    assign bus.doutA = dout_a_q;
    assign bus.doutB = dout_b_q;
  end else begin : g_read_comb
    assign bus.doutA = read_a;
    assign bus.doutB = read_b;
  end

endmodule

// File: tb/tb_regfile_nbit_bypass.sv
// Scoreboard bench: one combinational-read and one registered-read instance see identical
// stimulus; expectations are queued at issue time and popped by a negedge monitor.
module tb_regfile_nbit_bypass;

  logic clk;
  logic rst_n;
  int   cycle = 0;
  int   assertions = 0;
  int   failures = 0;

  typedef struct {
    int          due;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    string       name;
  } exp_t;

  exp_t comb_q[$];
  exp_t reg_q[$];
  exp_t mon_e;

  regfile_nbit_bypass_if #(.n(32), .AW(5)) bus_comb ();
  regfile_nbit_bypass_if #(.n(32), .AW(5)) bus_reg ();

  regfile_nbit_bypass #(.n(32), .DEPTH(32), .AW(5), .READ_REG(0)) dut_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_comb)
  );

  regfile_nbit_bypass #(.n(32), .DEPTH(32), .AW(5), .READ_REG(1)) dut_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input exp_t e, input string port,
                             input logic [31:0] act_a, input logic [31:0] act_b);
    assertions += 2;
    if (e.due != cycle) begin
      failures++;
      $display("[TB] FAIL %s/%s stale: checked in cycle %0d, due %0d", e.name, port, cycle, e.due);
    end
    if (act_a !== e.exp_a) begin
      failures++;
      $display("[TB] FAIL %s/%s doutA: got %h, expected %h", e.name, port, act_a, e.exp_a);
    end
    if (act_b !== e.exp_b) begin
      failures++;
      $display("[TB] FAIL %s/%s doutB: got %h, expected %h", e.name, port, act_b, e.exp_b);
    end
  endtask

  // Monitor: combinational results are due in the issue cycle, registered ones a cycle later.
  always @(negedge clk) begin
    while (comb_q.size() > 0 && comb_q[0].due <= cycle) begin
      mon_e = comb_q.pop_front();
      checkOutput(mon_e, "comb", bus_comb.doutA, bus_comb.doutB);
    end
    while (reg_q.size() > 0 && reg_q[0].due <= cycle) begin
      mon_e = reg_q.pop_front();
      checkOutput(mon_e, "reg", bus_reg.doutA, bus_reg.doutB);
    end
  end

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [3:0] be,
                               input logic [31:0] d, input logic [4:0] ra, input logic [4:0] rb,
                               input bit chk_comb, input bit chk_reg,
                               input logic [31:0] exp_a, input logic [31:0] exp_b,
                               input string name);
    exp_t e;
    @(posedge clk);
    #1;
    bus_comb.writeEnable = we;  bus_reg.writeEnable = we;
    bus_comb.writeAddr   = wa;  bus_reg.writeAddr   = wa;
    bus_comb.byteEn      = be;  bus_reg.byteEn      = be;
    bus_comb.din         = d;   bus_reg.din         = d;
    bus_comb.rdAddrA     = ra;  bus_reg.rdAddrA     = ra;
    bus_comb.rdAddrB     = rb;  bus_reg.rdAddrB     = rb;
    e.exp_a = exp_a;
    e.exp_b = exp_b;
    e.name  = name;
    if (chk_comb) begin
      e.due = cycle;
      comb_q.push_back(e);
    end
    if (chk_reg) begin
      e.due = cycle + 1;
      reg_q.push_back(e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_comb.writeEnable = 1'b0; bus_reg.writeEnable = 1'b0;
    bus_comb.writeAddr   = '0;   bus_reg.writeAddr   = '0;
    bus_comb.byteEn      = '0;   bus_reg.byteEn      = '0;
    bus_comb.din         = '0;   bus_reg.din         = '0;
    bus_comb.rdAddrA     = '0;   bus_reg.rdAddrA     = '0;
    bus_comb.rdAddrB     = '0;   bus_reg.rdAddrB     = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b0, 5'd0, 4'h0, 32'h0, 5'(a), 5'(31 - a), 1'b1, 1'b1, 32'h0, 32'h0, "reset_read");
    end

    // Full write, bypassed on A while B reads the zero entry.
    applyStimulus(1'b1, 5'd5, 4'hF, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h0, "write5_bypass");
    applyStimulus(1'b0, 5'd0, 4'h0, 32'h0, 5'd5, 5'd6, 1'b1, 1'b1, 32'hDEADBEEF, 32'h0, "read5");

    // Byte-masked write: bytes 0 and 2 replaced.
    applyStimulus(1'b1, 5'd5, 4'b0101, 32'h11223344, 5'd5, 5'd5, 1'b1, 1'b1, 32'hDE22BE44, 32'hDE22BE44, "mask5_bypass");
    applyStimulus(1'b0, 5'd0, 4'h0, 32'h0, 5'd5, 5'd5, 1'b1, 1'b1, 32'hDE22BE44, 32'hDE22BE44, "mask5_read");

    // Empty byte mask is a no-op; B bypasses a separate entry.
    applyStimulus(1'b1, 5'd5, 4'h0, 32'h00000000, 5'd5, 5'd5, 1'b1, 1'b1, 32'hDE22BE44, 32'hDE22BE44, "nomask5");
    applyStimulus(1'b1, 5'd9, 4'h1, 32'hFFFFFFAB, 5'd5, 5'd9, 1'b1, 1'b1, 32'hDE22BE44, 32'h000000AB, "byte9_bypassB");
    applyStimulus(1'b0, 5'd0, 4'h0, 32'h0, 5'd9, 5'd5, 1'b1, 1'b1, 32'h000000AB, 32'hDE22BE44, "read9");

    // Entry 0 stays zero, including through the bypass.
    applyStimulus(1'b1, 5'd0, 4'hF, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0, "write0_bypass");
    applyStimulus(1'b0, 5'd0, 4'h0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0, "read0");

    // Same-cycle write seen on both ports at once.
    applyStimulus(1'b1, 5'd7, 4'hF, 32'h0000CAFE, 5'd7, 5'd7, 1'b1, 1'b1, 32'h0000CAFE, 32'h0000CAFE, "write7_both");
    applyStimulus(1'b0, 5'd0, 4'h0, 32'h0, 5'd7, 5'd9, 1'b1, 1'b1, 32'h0000CAFE, 32'h000000AB, "read7");

    // Asynchronous reset mid-cycle, then a write held under reset across an edge.
    applyStimulus(1'b1, 5'd3, 4'hF, 32'h12345678, 5'd3, 5'd3, 1'b1, 1'b0, 32'h12345678, 32'h12345678, "fill3");
    applyStimulus(1'b0, 5'd0, 4'h0, 32'h0, 5'd3, 5'd7, 1'b1, 1'b1, 32'h0, 32'h0, "async_rst");
    #1 rst_n = 1'b0;
    applyStimulus(1'b1, 5'd3, 4'hF, 32'hFFFF0000, 5'd3, 5'd3, 1'b0, 1'b0, 32'h0, 32'h0, "write_in_rst");
    applyStimulus(1'b0, 5'd0, 4'h0, 32'h0, 5'd3, 5'd5, 1'b1, 1'b1, 32'h0, 32'h0, "rst_write_dropped");
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 5'd3, 4'hF, 32'h0BADF00D, 5'd3, 5'd0, 1'b1, 1'b1, 32'h0BADF00D, 32'h0, "post_rst_write");
    applyStimulus(1'b0, 5'd0, 4'h0, 32'h0, 5'd3, 5'd3, 1'b1, 1'b1, 32'h0BADF00D, 32'h0BADF00D, "post_rst_read");

    applyStimulus(1'b0, 5'd0, 4'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, "idle");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    assertions++;
    if (comb_q.size() != 0 || reg_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d comb and %0d reg expectations left, expected 0 and 0",
               comb_q.size(), reg_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
